// File: rtl/riscv_m_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_m_pkg
//  Description : Shared RV32M definitions: funct3 codes, MDU state encoding
//                and the opcode/funct7 pair that identifies an M-extension op.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_m_pkg;

  // RV32M funct3 encodings
  localparam logic [2:0] FN_MUL    = 3'b000;
  localparam logic [2:0] FN_MULH   = 3'b001;
  localparam logic [2:0] FN_MULHSU = 3'b010;
  localparam logic [2:0] FN_MULHU  = 3'b011;
  localparam logic [2:0] FN_DIV    = 3'b100;
  localparam logic [2:0] FN_DIVU   = 3'b101;
  localparam logic [2:0] FN_REM    = 3'b110;
  localparam logic [2:0] FN_REMU   = 3'b111;

  // Decoder constants that qualify in_valid
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // True when the instruction fields denote an RV32M operation
  function automatic logic is_m_op(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv
//  Description : Iterative RV32M multiply/divide unit for the execute stage.
//                Shift-add multiply and restoring divide, one bit per cycle,
//                with a sign-fix cycle; divide special cases finish at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv
  import riscv_m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [2:0]      fnc3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_rd
);

  localparam int              c_cw   = $clog2(XLEN);
  localparam logic [c_cw-1:0] c_last = c_cw'(XLEN - 1);
  localparam logic [XLEN-1:0] c_min  = {1'b1, {(XLEN-1){1'b0}}};

  state_t             r_state;
  state_t             w_next;
  logic [2:0]         r_fn;
  logic [4:0]         r_rd;
  logic [c_cw-1:0]    r_count;
  logic [2*XLEN-1:0]  r_acc;      // product {hi,lo}; for divide, lo is dividend/quotient
  logic [XLEN-1:0]    r_opnd;     // multiplicand or divisor magnitude
  logic [XLEN-1:0]    r_rem;      // partial remainder (always below the divisor)
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [XLEN-1:0]    r_result;

  logic               w_accept;
  logic               w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]    w_a_mag, w_b_mag;
  logic               w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0]    w_special_res;
  logic [XLEN:0]      w_mul_sum;
  logic [XLEN:0]      w_shift, w_trial;
  logic               w_qbit;
  logic [2*XLEN-1:0]  w_prod;
  logic [XLEN-1:0]    w_quo, w_rmd, w_fix_res;

  assign w_accept   = (r_state == IDLE) & in_valid & ~flush;
  assign w_a_signed = (fnc3 == FN_MULH) | (fnc3 == FN_MULHSU) | (fnc3 == FN_DIV) | (fnc3 == FN_REM);
  assign w_b_signed = (fnc3 == FN_MULH) | (fnc3 == FN_DIV) | (fnc3 == FN_REM);
  assign w_a_neg    = w_a_signed & rs1_val[XLEN-1];
  assign w_b_neg    = w_b_signed & rs2_val[XLEN-1];
  assign w_a_mag    = w_a_neg ? -rs1_val : rs1_val;
  assign w_b_mag    = w_b_neg ? -rs2_val : rs2_val;

  // Divide by zero and signed overflow bypass the iteration entirely
  assign w_div_zero    = fnc3[2] & (rs2_val == '0);
  assign w_div_ovf     = fnc3[2] & ~fnc3[0] & (rs1_val == c_min) & (rs2_val == '1);
  assign w_special     = w_div_zero | w_div_ovf;
  assign w_special_res = w_div_zero ? (fnc3[1] ? rs1_val : '1)
                                    : (fnc3[1] ? '0 : c_min);

  // One multiply step: add multiplicand into the high half when the low bit is set
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

  // One restoring divide step on the 33-bit shifted remainder
  assign w_shift = {r_rem, r_acc[XLEN-1]};
  assign w_trial = w_shift - {1'b0, r_opnd};
  assign w_qbit  = ~w_trial[XLEN];

  // Sign correction applied in FIX
  assign w_prod    = r_neg_res ? -r_acc : r_acc;
  assign w_quo     = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rmd     = r_neg_rem ? -r_rem : r_rem;
  assign w_fix_res = r_fn[2] ? (r_fn[1] ? w_rmd : w_quo)
                             : ((r_fn == FN_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_special ? DONE : CALC;
      CALC: if (r_count == c_last) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  // Operand capture, iteration and result registration
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fn      <= '0;
      r_rd      <= '0;
      r_count   <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_rem     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_fn      <= fnc3;
          r_rd      <= rd;
          r_count   <= '0;
          r_rem     <= '0;
          r_neg_res <= w_a_neg ^ w_b_neg;
          r_neg_rem <= w_a_neg;
          r_opnd    <= fnc3[2] ? w_b_mag : w_a_mag;
          r_acc     <= {{XLEN{1'b0}}, (fnc3[2] ? w_a_mag : w_b_mag)};
          if (w_special) r_result <= w_special_res;
        end
        CALC: begin
          r_count <= r_count + c_cw'(1);
          if (r_fn[2]) begin
            r_rem            <= w_qbit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
            r_acc[XLEN-1:0]  <= {r_acc[XLEN-2:0], w_qbit};
          end else begin
            r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
          end
        end
        FIX: if (!flush) r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign stall     = in_valid & (r_state != DONE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign out_rd    = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv
//  Description : Directed self-checking bench for ex_muldiv.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;
  import riscv_m_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [2:0]  fnc3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        out_valid;
  logic [31:0] result;
  logic [4:0]  out_rd;

  int n_total = 0;
  int n_bad   = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .fnc3(fnc3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd(rd), .flush(flush),
    .stall(stall), .busy(busy), .out_valid(out_valid),
    .result(result), .out_rd(out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic present(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r);
    @(negedge clk);
    in_valid = 1'b1;
    fnc3     = fn;
    rs1_val  = a;
    rs2_val  = b;
    rd       = r;
  endtask

  // Edges counted include the accept edge; stalls counted after accept until valid
  task automatic wait_valid(input string tag, output int edges, output int stalls);
    edges  = 0;
    stalls = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (!out_valid && stall) stalls++;
    end while (!out_valid && edges < 200);
    check({tag, "_reached_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r,
                       input logic [31:0] exp, input int exp_edges);
    int e, s;
    present(fn, a, b, r);
    wait_valid(tag, e, s);
    check({tag, "_result"}, result, exp);
    check({tag, "_rd"}, {27'd0, out_rd}, {27'd0, r});
    check({tag, "_edges"}, e, exp_edges);
    check({tag, "_stall_cycles"}, s, exp_edges - 1);
    check({tag, "_stall_in_done"}, {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_single_pulse"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int e, s;
    rst = 1'b0; in_valid = 1'b0; fnc3 = '0; rs1_val = '0; rs2_val = '0; rd = '0; flush = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_result",    result,             32'd0);
    check("rst_out_rd",    {27'd0, out_rd},    32'd0);
    check("rst_stall_lo",  {31'd0, stall},     32'd0);
    in_valid = 1'b1;
    #1;
    check("rst_stall_follows", {31'd0, stall}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Multiply
    do_op("mul_7xm3",    FN_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 34);
    do_op("mulhu_ff",    FN_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 34);
    do_op("mulh_ff",     FN_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 34);
    do_op("mulhsu_ff",   FN_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 34);
    do_op("mul_ff",      FN_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'h00000001, 34);

    // Divide
    do_op("div_m7_2",    FN_DIV,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 34);
    do_op("rem_m7_2",    FN_REM,    32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 34);
    do_op("divu_m7_2",   FN_DIVU,   32'hFFFFFFF9, 32'd2,        5'd12, 32'h7FFFFFFC, 34);
    do_op("remu_m7_2",   FN_REMU,   32'hFFFFFFF9, 32'd2,        5'd13, 32'h00000001, 34);
    do_op("divu_min_m1", FN_DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, 34);
    do_op("remu_min_m1", FN_REMU,   32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 34);

    // Special cases finish on the accept edge
    do_op("div_5_0",     FN_DIV,    32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, 1);
    do_op("rem_5_0",     FN_REM,    32'd5,        32'd0,        5'd17, 32'h00000005, 1);
    do_op("div_ovf",     FN_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1);
    do_op("rem_ovf",     FN_REM,    32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h00000000, 1);

    // Flush during the 10th CALC cycle of a DIV, then a MUL follows
    present(FN_DIV, 32'd100, 32'd7, 5'd20);
    @(posedge clk);
    #1;
    check("flush_busy_after_accept", {31'd0, busy}, 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush_busy",      {31'd0, busy},      32'd0);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    flush   = 1'b0;
    fnc3    = FN_MUL;
    rs1_val = 32'd1234;
    rs2_val = 32'd1000;
    rd      = 5'd21;
    wait_valid("post_flush_mul", e, s);
    check("post_flush_mul_result", result, 32'd1234000);
    check("post_flush_mul_rd", {27'd0, out_rd}, 32'd21);
    check("post_flush_mul_edges", e, 34);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Asynchronous reset in the middle of CALC
    present(FN_DIVU, 32'd1000, 32'd3, 5'd9);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result",    result,             32'd0);
    check("midrst_out_rd",    {27'd0, out_rd},    32'd0);
    check("midrst_busy",      {31'd0, busy},      32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    do_op("after_rst_mulhu", FN_MULHU, 32'h00010000, 32'h00030000, 5'd3, 32'h00000003, 34);
    do_op("after_rst_divu",  FN_DIVU,  32'd1000,     32'd3,        5'd4, 32'd333,      34);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Absolute guard against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
